fetch_prefetch_queue: RTL and testbench

FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

---
 rtl/fetch_prefetch_queue.sv | 161 ++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_queue
// Brief    : Instruction prefetch FIFO with program-load mode and branch flush.
//            Optional same-cycle bypass of responses into an empty queue when
//            FETCH_PREFETCH_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          INSTR_W  = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         program_mem_write_en_i,
    input  logic [INSTR_W-1:0]           instruction_i,
    input  logic [31:0]                  instruction_addr_i,
    input  logic                         take_branch_i,
    input  logic [31:0]                  branch_pc_value_i,
    input  logic                         stall_pipeline_i,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [31:0]                  mem_addr_o,
    output logic [INSTR_W-1:0]           mem_wdata_o,
    input  logic [INSTR_W-1:0]           mem_rdata_i,
    output logic                         is_valid_o,
    output logic [INSTR_W-1:0]           instruction_o,
    output logic [31:0]                  program_counter_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_CW = $clog2(DEPTH+1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [INSTR_W-1:0]  r_instr_q [DEPTH];
    logic [31:0]         r_pc_q    [DEPTH];
    logic [C_AW-1:0]     r_wr_ptr;
    logic [C_AW-1:0]     r_rd_ptr;
    logic [C_CW-1:0]     r_count;
    logic                r_inflight;
    logic [31:0]         r_inflight_pc;
    logic [31:0]         r_fetch_pc;

    logic                w_load;
    logic                w_first_run;
    logic                w_rd_issue;
    logic                w_resp;
    logic                w_push;
    logic                w_pop;
    logic                w_head_valid;
    logic [INSTR_W-1:0]  w_head_instr;
    logic [31:0]         w_head_pc;
    logic [31:0]         w_fetch_addr;
    logic [C_CW:0]       w_occupancy;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_RUN;
        if (program_mem_write_en_i) begin
            w_state_next = S_LOAD;
        end
    end

    assign w_load      = (w_state_next == S_LOAD);
    // Leaving load mode always restarts fetch from the reset vector.
    assign w_first_run = (r_state == S_LOAD) && !w_load;
    assign w_fetch_addr = w_first_run ? RESET_PC : r_fetch_pc;

    // Outstanding read counts against capacity so the queue cannot overflow.
    assign w_occupancy = {1'b0, r_count} + (C_CW+1)'(r_inflight);
    assign w_rd_issue  = !w_load && !take_branch_i && (w_occupancy < (C_CW+1)'(DEPTH));
    assign w_resp      = r_inflight && !w_load && !take_branch_i;

`ifdef FETCH_PREFETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass     = w_resp && (r_count == '0);
    assign w_head_valid = (r_count != '0) || w_bypass;
    assign w_head_instr = w_bypass ? mem_rdata_i   : r_instr_q[r_rd_ptr];
    assign w_head_pc    = w_bypass ? r_inflight_pc : r_pc_q[r_rd_ptr];
    // A bypassed response consumed by decode never enters the queue.
    assign w_push       = w_resp && !(w_bypass && !stall_pipeline_i);
`else
    assign w_head_valid = (r_count != '0);
    assign w_head_instr = r_instr_q[r_rd_ptr];
    assign w_head_pc    = r_pc_q[r_rd_ptr];
    assign w_push       = w_resp;
`endif

    assign w_pop = (r_count != '0) && !stall_pipeline_i && !take_branch_i && !w_load;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_fetch_pc    <= RESET_PC;
        end else if (w_load) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_inflight    <= 1'b0;
            r_fetch_pc    <= RESET_PC;
        end else if (take_branch_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_inflight    <= 1'b0;
            r_fetch_pc    <= branch_pc_value_i;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= r_count + C_CW'(w_push) - C_CW'(w_pop);
            r_inflight <= w_rd_issue;
            if (w_rd_issue) begin
                r_inflight_pc <= w_fetch_addr;
                r_fetch_pc    <= w_fetch_addr + 32'd2;
            end
        end
    end

    // Storage needs no reset: the head is only visible while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_instr_q[r_wr_ptr] <= mem_rdata_i;
            r_pc_q[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    assign mem_en_o          = reset_i && (w_load || w_rd_issue);
    assign mem_we_o          = reset_i && w_load;
    assign mem_addr_o        = !reset_i ? 32'h0 : (w_load ? instruction_addr_i : w_fetch_addr);
    assign mem_wdata_o       = (reset_i && w_load) ? instruction_i : '0;
    assign is_valid_o        = reset_i && w_head_valid;
    assign instruction_o     = is_valid_o ? w_head_instr : '0;
    assign program_counter_o = is_valid_o ? w_head_pc : 32'h0;
    assign count_o           = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch_queue
// Brief    : Directed self-checking bench for fetch_prefetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;

    localparam int DEPTH   = 4;
    localparam int INSTR_W = 16;
`ifdef FETCH_PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               reset_i = 1'b0;
    logic               program_mem_write_en_i = 1'b0;
    logic [INSTR_W-1:0] instruction_i = '0;
    logic [31:0]        instruction_addr_i = '0;
    logic               take_branch_i = 1'b0;
    logic [31:0]        branch_pc_value_i = '0;
    logic               stall_pipeline_i = 1'b0;
    logic               mem_en_o;
    logic               mem_we_o;
    logic [31:0]        mem_addr_o;
    logic [INSTR_W-1:0] mem_wdata_o;
    logic [INSTR_W-1:0] mem_rdata_i = '0;
    logic               is_valid_o;
    logic [INSTR_W-1:0] instruction_o;
    logic [31:0]        program_counter_o;
    logic [2:0]         count_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] tb_mem [256];

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .INSTR_W  (INSTR_W),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .program_mem_write_en_i (program_mem_write_en_i),
        .instruction_i          (instruction_i),
        .instruction_addr_i     (instruction_addr_i),
        .take_branch_i          (take_branch_i),
        .branch_pc_value_i      (branch_pc_value_i),
        .stall_pipeline_i       (stall_pipeline_i),
        .mem_en_o               (mem_en_o),
        .mem_we_o               (mem_we_o),
        .mem_addr_o             (mem_addr_o),
        .mem_wdata_o            (mem_wdata_o),
        .mem_rdata_i            (mem_rdata_i),
        .is_valid_o             (is_valid_o),
        .instruction_o          (instruction_o),
        .program_counter_o      (program_counter_o),
        .count_o                (count_o)
    );

    // Program memory: halfword at pc holds 16'hC000 | pc[8:1] until rewritten.
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) tb_mem[mem_addr_o[8:1]] <= mem_wdata_o;
            else          mem_rdata_i <= tb_mem[mem_addr_o[8:1]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},    32'(mem_en_o), 32'h0);
        check({tag, "_we"},    32'(mem_we_o), 32'h0);
        check({tag, "_addr"},  mem_addr_o, 32'h0);
        check({tag, "_wdata"}, 32'(mem_wdata_o), 32'h0);
        check({tag, "_valid"}, 32'(is_valid_o), 32'h0);
        check({tag, "_instr"}, 32'(instruction_o), 32'h0);
        check({tag, "_pc"},    program_counter_o, 32'h0);
        check({tag, "_count"}, 32'(count_o), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 16'hC000 | 16'(i);

        // Reset state and streaming fetch
        repeat (3) step();
        program_mem_write_en_i = 1'b1;
        @(negedge clk);
        check_all_zero("rst");
        step();
        program_mem_write_en_i = 1'b0;
        reset_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t1_en",   32'(mem_en_o), 32'h1);
            check("t1_addr", mem_addr_o, 32'(2 * k));
            check("t1_valid", 32'(is_valid_o), 32'(k >= LAT));
            if (k >= LAT) begin
                check("t1_pc",    program_counter_o, 32'(2 * (k - LAT)));
                check("t1_instr", 32'(instruction_o), 32'h0000_C000 | 32'(k - LAT));
            end
            step();
        end

        // Stall: queue fills to DEPTH, then drains in order
        reset_i = 1'b0;
        step();
        stall_pipeline_i = 1'b1;
        reset_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 7) begin
                check("t2_count_full", 32'(count_o), 32'd4);
                check("t2_en_full",    32'(mem_en_o), 32'h0);
                check("t2_valid_full", 32'(is_valid_o), 32'h1);
            end
            step();
        end
        stall_pipeline_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_pop_pc",    program_counter_o, 32'(2 * k));
            check("t2_pop_instr", 32'(instruction_o), 32'h0000_C000 | 32'(k));
            step();
        end

        // Branch flush with count=3 and a read in flight
        reset_i = 1'b0;
        step();
        stall_pipeline_i = 1'b1;
        reset_i = 1'b1;
        repeat (4) step();
        take_branch_i = 1'b1;
        branch_pc_value_i = 32'h40;
        @(negedge clk);
        check("t3_count_pre", 32'(count_o), 32'd3);
        check("t3_en_branch", 32'(mem_en_o), 32'h0);
        step();
        take_branch_i = 1'b0;
        @(negedge clk);
        check("t3_count_flush", 32'(count_o), 32'd0);
        check("t3_en_redirect", 32'(mem_en_o), 32'h1);
        check("t3_addr_redirect", mem_addr_o, 32'h40);
        check("t3_valid_flush", 32'(is_valid_o), 32'h0);
        step();
        @(negedge clk);
        check("t3_valid_c6", 32'(is_valid_o), 32'(LAT == 1));
        step();
        @(negedge clk);
        check("t3_valid_c7", 32'(is_valid_o), 32'h1);
        check("t3_pc_c7",    program_counter_o, 32'h40);
        check("t3_instr_c7", 32'(instruction_o), 32'h0000_C020);
        step();
        @(negedge clk);
        check("t3_count_c8", 32'(count_o), 32'd2);
        check("t3_pc_c8",    program_counter_o, 32'h40);
        step();

        // Load mode writes 0xBEEF at 0x10, then fetch restarts at 0
        program_mem_write_en_i = 1'b1;
        instruction_i = 16'hBEEF;
        instruction_addr_i = 32'h10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_en",    32'(mem_en_o), 32'h1);
            check("t4_we",    32'(mem_we_o), 32'h1);
            check("t4_addr",  mem_addr_o, 32'h10);
            check("t4_wdata", 32'(mem_wdata_o), 32'h0000_BEEF);
            if (k >= 1) check("t4_count", 32'(count_o), 32'd0);
            step();
        end
        program_mem_write_en_i = 1'b0;
        stall_pipeline_i = 1'b0;
        @(negedge clk);
        check("t4_run_en",   32'(mem_en_o), 32'h1);
        check("t4_run_we",   32'(mem_we_o), 32'h0);
        check("t4_run_addr", mem_addr_o, 32'h0);
        for (int k = 0; k < LAT + 8; k++) step();
        @(negedge clk);
        check("t4_beef_pc",    program_counter_o, 32'h10);
        check("t4_beef_instr", 32'(instruction_o), 32'h0000_BEEF);
        step();

        // Asynchronous reset mid-stream with count=2
        stall_pipeline_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (count_o == 3'd2) break;
            step();
        end
        check("t5_count2", 32'(count_o), 32'd2);
        #2;
        reset_i = 1'b0;
        #1;
        check_all_zero("t5_async");
        step();
        step();
        reset_i = 1'b1;
        @(negedge clk);
        check("t5_restart_en",   32'(mem_en_o), 32'h1);
        check("t5_restart_addr", mem_addr_o, 32'h0);
        check("t5_restart_valid", 32'(is_valid_o), 32'h0);
        for (int k = 0; k < LAT; k++) step();
        @(negedge clk);
        check("t5_first_valid", 32'(is_valid_o), 32'h1);
        check("t5_first_pc",    program_counter_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
